// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, keeps one instruction-memory read
// outstanding, applies jump/branch and trap redirects, and hands instructions to ID.
module if_fetch_ctrl #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] PC_START = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_fetch_stall_i,
  input  logic              if_fetch_jumpbranch_en_i,
  input  logic [ADDR_W-1:0] if_fetch_jumpbranch_addr_i,
  input  logic              if_fetch_trap_en_i,
  input  logic [ADDR_W-1:0] if_fetch_trap_addr_i,
  output logic              if_fetch_req_valid_o,
  output logic [ADDR_W-1:0] if_fetch_req_addr_o,
  input  logic              if_fetch_req_ready_i,
  input  logic              if_fetch_rsp_valid_i,
  input  logic [INST_W-1:0] if_fetch_rsp_data_i,
  output logic              if_fetch_inst_valid_o,
  output logic [INST_W-1:0] if_fetch_inst_o,
  output logic [ADDR_W-1:0] if_fetch_inst_addr_o,
  input  logic              if_fetch_id_ready_i,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. The request may be withdrawn or retargeted by a redirect before it is
  // accepted; the response side has no ready and arrives exactly once per accept.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic              kill, kill_n;
  logic [INST_W-1:0] inst_r, inst_n;
  logic [ADDR_W-1:0] inst_addr_r, inst_addr_n;
  logic              redir;
  logic [ADDR_W-1:0] tgt;
  logic              req_fire;

  assign redir = if_fetch_trap_en_i | if_fetch_jumpbranch_en_i;
  assign tgt   = if_fetch_trap_en_i ? if_fetch_trap_addr_i : if_fetch_jumpbranch_addr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= PC_START;
      kill        <= 1'b0;
      inst_r      <= '0;
      inst_addr_r <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      kill        <= kill_n;
      inst_r      <= inst_n;
      inst_addr_r <= inst_addr_n;
    end
  end

  always_comb begin
    state_n               = state;
    pc_n                  = pc;
    kill_n                = kill;
    inst_n                = inst_r;
    inst_addr_n           = inst_addr_r;
    req_fire              = 1'b0;
    if_fetch_req_valid_o  = 1'b0;
    if_fetch_inst_valid_o = 1'b0;
    case (state)
      S_REQ: begin
        if_fetch_req_valid_o = ~if_fetch_stall_i & ~redir;
        req_fire             = ~if_fetch_stall_i & ~redir & if_fetch_req_ready_i;
        if (redir) begin
          pc_n = tgt;
        end else if (req_fire) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_n   = tgt;
          kill_n = 1'b1;
        end
        // A same-cycle redirect makes the arriving word stale as well.
        if (if_fetch_rsp_valid_i) begin
          if (kill | redir) begin
            kill_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            inst_n      = if_fetch_rsp_data_i;
            inst_addr_n = pc;
            state_n     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // A redirect here comes from an older instruction, so the held one dies now.
        if_fetch_inst_valid_o = ~redir;
        if (redir) begin
          pc_n    = tgt;
          state_n = S_REQ;
        end else if (if_fetch_id_ready_i) begin
          pc_n    = pc + ADDR_W'(4);
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

  assign if_fetch_req_addr_o  = pc;
  assign if_fetch_inst_o      = inst_r;
  assign if_fetch_inst_addr_o = inst_addr_r;
  assign dbg_state            = state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level fetch model.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, jb_en, trap_en, req_ready, rsp_valid, id_ready;
  logic [63:0] jb_addr, trap_addr;
  logic [31:0] rsp_data;
  logic        req_valid_o, inst_valid_o;
  logic [63:0] req_addr_o, inst_addr_o;
  logic [31:0] inst_o;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk                        (clk),
    .rst                        (rst),
    .if_fetch_stall_i           (stall),
    .if_fetch_jumpbranch_en_i   (jb_en),
    .if_fetch_jumpbranch_addr_i (jb_addr),
    .if_fetch_trap_en_i         (trap_en),
    .if_fetch_trap_addr_i       (trap_addr),
    .if_fetch_req_valid_o       (req_valid_o),
    .if_fetch_req_addr_o        (req_addr_o),
    .if_fetch_req_ready_i       (req_ready),
    .if_fetch_rsp_valid_i       (rsp_valid),
    .if_fetch_rsp_data_i        (rsp_data),
    .if_fetch_inst_valid_o      (inst_valid_o),
    .if_fetch_inst_o            (inst_o),
    .if_fetch_inst_addr_o       (inst_addr_o),
    .if_fetch_id_ready_i        (id_ready),
    .dbg_state                  (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5a5a_0f0f;
  endfunction

  // ---------------- memory model and logs ----------------
  int          mem_lat = 1;  // 0 selects a random latency 1..4
  bit          mem_pend = 0;
  int          mem_rem  = 0;
  logic [63:0] mem_addr = '0;
  bit          acc_last = 0, rsp_last = 0, rst_last = 1, iv_last = 0;
  logic [63:0] acc_addr = '0;
  int          cyc = 0;
  logic [63:0] req_log[$];
  logic [63:0] dlv_log[$];
  int          acc_cyc[$];

  task automatic cycle(input logic st, input logic jb, input logic [63:0] ja,
                       input logic tr, input logic [63:0] ta,
                       input logic rr, input logic ir);
    if (rst_last) begin
      mem_pend = 0;
    end else begin
      if (rsp_last) mem_pend = 0;
      else if (mem_pend && mem_rem > 0) mem_rem--;
      if (acc_last) begin
        mem_pend = 1;
        mem_rem  = ((mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat) - 1;
        mem_addr = acc_addr;
      end
    end
    rsp_valid = mem_pend && (mem_rem == 0);
    rsp_data  = rsp_valid ? word(mem_addr) : $urandom();
    stall = st; jb_en = jb; jb_addr = ja; trap_en = tr; trap_addr = ta;
    req_ready = rr; id_ready = ir;
    @(negedge clk);
    acc_last = req_valid_o && req_ready && !rst;
    acc_addr = req_addr_o;
    rsp_last = rsp_valid;
    rst_last = rst;
    iv_last  = inst_valid_o;
    if (acc_last) begin
      req_log.push_back(req_addr_o);
      acc_cyc.push_back(cyc);
    end
    if (inst_valid_o && id_ready && !rst) dlv_log.push_back(inst_addr_o);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ir = 1'b1);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, ir);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    req_log.delete();
    dlv_log.delete();
    acc_cyc.delete();
    cyc = 0;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit          m_on = 0;
  logic [63:0] m_pc;
  bit          m_out, m_drop, m_held;
  logic [31:0] m_inst;
  logic [63:0] m_iaddr;

  always @(negedge clk) begin
    logic        redir, e_rv, stale;
    logic [63:0] tgt;
    if (rst) begin
      m_on = 1; m_pc = 64'h8000_0000; m_out = 0; m_drop = 0; m_held = 0;
      m_inst = '0; m_iaddr = '0;
    end else if (m_on) begin
      redir = trap_en | jb_en;
      tgt   = trap_en ? trap_addr : jb_addr;
      e_rv  = !m_out && !m_held && !stall && !redir;
      chk("req_valid", {63'b0, req_valid_o}, {63'b0, e_rv});
      chk("req_addr", req_addr_o, m_pc);
      chk("inst_valid", {63'b0, inst_valid_o}, {63'b0, m_held && !redir});
      if (m_held && !redir) begin
        chk("inst", {32'b0, inst_o}, {32'b0, m_inst});
        chk("inst_addr", inst_addr_o, m_iaddr);
      end
      if (m_held) begin
        if (redir) begin m_pc = tgt; m_held = 0; end
        else if (id_ready) begin m_pc = m_pc + 64'd4; m_held = 0; end
      end else if (m_out) begin
        stale = m_drop || redir;
        if (redir) begin m_pc = tgt; m_drop = 1; end
        if (rsp_valid) begin
          m_out = 0;
          if (stale) m_drop = 0;
          else begin m_held = 1; m_inst = rsp_data; m_iaddr = m_pc; end
        end
      end else begin
        if (redir) m_pc = tgt;
        else if (e_rv && req_ready) m_out = 1;
      end
    end
  end

  function automatic logic [63:0] rand_tgt();
    case ($urandom_range(0, 3))
      0: return 64'h8000_0000 + 64'($urandom_range(0, 255) * 4);
      1: return 64'hFFFF_FFFF_FFFF_FFF8;
      2: return 64'hFFFF_FFFF_FFFF_FFFC;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    rst = 1'b1; stall = 0; jb_en = 0; trap_en = 0; jb_addr = '0; trap_addr = '0;
    req_ready = 0; rsp_valid = 0; rsp_data = '0; id_ready = 0;
    @(posedge clk);
    #1;

    // Straight-line fetch with 1-cycle memory: one instruction per 3 cycles.
    mem_lat = 1;
    do_reset();
    chk("rst_req_addr", req_addr_o, 64'h8000_0000);
    chk("rst_inst_valid", {63'b0, inst_valid_o}, 64'd0);
    chk("rst_req_valid", {63'b0, req_valid_o}, 64'd1);
    idle(8);
    chk("t1_req_count", 64'(req_log.size()), 64'd3);
    if (req_log.size() == 3) begin
      chk("t1_req0", req_log[0], 64'h8000_0000);
      chk("t1_req1", req_log[1], 64'h8000_0004);
      chk("t1_req2", req_log[2], 64'h8000_0008);
      chk("t1_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
      chk("t1_gap1", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);
    end
    chk("t1_dlv_count", 64'(dlv_log.size()), 64'd2);
    if (dlv_log.size() == 2) chk("t1_dlv1", dlv_log[1], 64'h8000_0004);

    // Jump while holding 0x80000008.
    chk("t2_hold_addr", inst_addr_o, 64'h8000_0008);
    chk("t2_hold_data", {32'b0, inst_o}, {32'b0, word(64'h8000_0008)});
    cycle(1'b0, 1'b1, 64'h8000_1000, 1'b0, '0, 1'b1, 1'b1);
    chk("t2_kill_valid", {63'b0, iv_last}, 64'd0);
    chk("t2_new_pc", req_addr_o, 64'h8000_1000);

    // Redirect during a 4-cycle wait: stale word dropped, refetch at target.
    mem_lat = 4;
    req_log.delete(); dlv_log.delete();
    idle(1);
    cycle(1'b0, 1'b1, 64'h8000_2000, 1'b0, '0, 1'b1, 1'b1);
    idle(4);
    chk("t3_req_count", 64'(req_log.size()), 64'd2);
    if (req_log.size() == 2) begin
      chk("t3_req0", req_log[0], 64'h8000_1000);
      chk("t3_req1", req_log[1], 64'h8000_2000);
    end
    chk("t3_no_dlv", 64'(dlv_log.size()), 64'd0);
    idle(6);
    chk("t3_dlv_count", 64'(dlv_log.size()), 64'd1);
    if (dlv_log.size() == 1) chk("t3_dlv0", dlv_log[0], 64'h8000_2000);

    // Trap and jump together: trap wins.
    mem_lat = 1;
    do_reset();
    cycle(1'b1, 1'b1, 64'h8000_3000, 1'b1, 64'h8000_0100, 1'b1, 1'b1);
    chk("t4_trap_prio", req_addr_o, 64'h8000_0100);
    idle(3);
    if (req_log.size() > 0) chk("t4_first_req", req_log[0], 64'h8000_0100);
    else chk("t4_first_req_seen", 64'd0, 64'd1);

    // Stall in REQ, then ID back-pressure in HOLD.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    chk("t5_no_req_stalled", 64'(req_log.size()), 64'd0);
    chk("t5_pc_stalled", req_addr_o, 64'h8000_0000);
    idle(5, 1'b0);
    chk("t5_held_addr", inst_addr_o, 64'h8000_0000);
    chk("t5_held_data", {32'b0, inst_o}, {32'b0, word(64'h8000_0000)});
    chk("t5_held_valid", {63'b0, inst_valid_o}, 64'd1);
    chk("t5_pc_held", req_addr_o, 64'h8000_0000);
    chk("t5_no_dlv", 64'(dlv_log.size()), 64'd0);
    idle(1);
    chk("t5_pc_after", req_addr_o, 64'h8000_0004);
    chk("t5_dlv", 64'(dlv_log.size()), 64'd1);

    // Reset while a fetch is outstanding.
    mem_lat = 4;
    do_reset();
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t6_req_addr", req_addr_o, 64'h8000_0000);
    chk("t6_inst_valid", {63'b0, inst_valid_o}, 64'd0);
    chk("t6_req_valid", {63'b0, req_valid_o}, 64'd1);
    idle(8);

    // Randomized traffic against the model.
    mem_lat = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, rand_tgt(),
            $urandom_range(0, 24) == 0, rand_tgt(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end
    rst = 1'b0;
    chk("rand_progress", {63'b0, dlv_log.size() > 50}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer for the pipelined core's IF stage. Owns the fetch PC and the instruction-memory request/response handshake, and keeps one fetch outstanding. Applies jump/branch and trap redirects, including killing an in-flight fetch. Presents each fetched instruction with its address to ID through a valid/ready handshake.

## Interface
- `ADDR_W`, 64, fetch address width
- `INST_W`, 32, instruction width
- `PC_START`, 64'h8000_0000, fetch address after reset
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_fetch_stall_i`  in  1  downstream hazard; no new request issued while high
- `if_fetch_jumpbranch_en_i`  in  1  jump/branch redirect strobe, one cycle
- `if_fetch_jumpbranch_addr_i`  in  ADDR_W  jump/branch target
- `if_fetch_trap_en_i`  in  1  trap/mret redirect strobe, one cycle
- `if_fetch_trap_addr_i`  in  ADDR_W  trap target
- `if_fetch_req_valid_o`  out  1  memory read request
- `if_fetch_req_addr_o`  out  ADDR_W  request address, always equal to current PC
- `if_fetch_req_ready_i`  in  1  memory accepts request
- `if_fetch_rsp_valid_i`  in  1  read data valid; exactly one per accepted request, earliest the cycle after accept
- `if_fetch_rsp_data_i`  in  INST_W  instruction word
- `if_fetch_inst_valid_o`  out  1  instruction to ID valid
- `if_fetch_inst_o`  out  INST_W  instruction to ID
- `if_fetch_inst_addr_o`  out  ADDR_W  address of `if_fetch_inst_o`
- `if_fetch_id_ready_i`  in  1  ID accepts instruction

## Operation
- Registers:
  - `pc`
  - `kill` flag
  - `inst_r` and `inst_addr_r`
  - 2-bit `state`, one of REQ, WAIT or HOLD
- Redirect: `redir = trap_en | jumpbranch_en`. `tgt = trap_en ? trap_addr : jumpbranch_addr`; trap has priority when both are set. Targets are used verbatim; alignment is checked elsewhere.
- REQ:
  - `req_valid_o = ~stall_i & ~redir`.
  - If `redir`: `pc <= tgt`, stay in REQ. The request may be retargeted before it is accepted; the bus permits this.
  - Else if `req_valid_o & req_ready_i`: go to WAIT.
- WAIT:
  - `req_valid_o = 0`.
  - If `redir`: `pc <= tgt`, `kill <= 1`.
  - On `rsp_valid_i` with `kill` (or with `redir` in the same cycle): drop the data, clear `kill`, go to REQ.
  - On `rsp_valid_i` otherwise: `inst_r <= rsp_data_i`, `inst_addr_r <= pc`, go to HOLD.
- HOLD:
  - `inst_valid_o = ~redir`; this is combinational kill, since a same-cycle redirect belongs to an older instruction.
  - If `redir`: `pc <= tgt`, go to REQ; the held instruction is discarded and any ID handshake that cycle is ignored.
  - Else if `id_ready_i`: `pc <= pc + 4`, go to REQ.
- `stall_i` only gates new requests. An outstanding fetch completes, and HOLD is unaffected.
- `pc + 4` wraps modulo 2^ADDR_W.
- `inst_o`/`inst_addr_o` are driven from `inst_r`/`inst_addr_r`.

## Timing
- Reset (`rst` high at an edge):
  - state REQ, `pc = PC_START`, `kill = 0`, `inst_r = 0`, `inst_addr_r = 0`.
  - Outputs: `inst_valid_o = 0`; `req_valid_o = 1` the first cycle after reset unless stalled.
  - Reset mid-operation aborts everything. The memory shares `rst`, so no stale response follows.
- Best-case throughput with single-cycle memory and ID always ready is one instruction per 3 cycles:
  - cycle t: REQ accept
  - cycle t+1: rsp
  - cycle t+2: HOLD/deliver
  - cycle t+3: next REQ
- `pc` updates at the edge ending the redirect cycle. The first request to `tgt` is valid in the cycle after a redirect seen in REQ or HOLD.
- A redirect in WAIT delays the first request to `tgt` until the cycle after the stale response.
- A second redirect while `kill` is set overwrites `pc` again; `kill` stays set and only one response is dropped.
- `inst_valid_o` stays high and `inst_o`/`inst_addr_o` stay stable until the handshake or a redirect.

## Test plan
- Reset, 1-cycle memory, ID always ready, no stall -> requests at 0x80000000, 0x80000004, 0x80000008, one per 3 cycles; each `inst_addr_o` matches its data.
- `jumpbranch_en` with target 0x80001000 while in HOLD at 0x80000008 -> `inst_valid_o` low that cycle; next request is 0x80001000; 0x8000000C is never delivered.
- Redirect to 0x80002000 during WAIT with response latency 4 -> stale response dropped, nothing reaches ID; next request is 0x80002000.
- `trap_en` (0x80000100) and `jumpbranch_en` (0x80003000) in the same cycle -> `pc` becomes 0x80000100.
- `stall_i` held 5 cycles in REQ, then `id_ready_i` low 3 cycles in HOLD -> no request during the stall; instruction held stable; `pc` advances by 4 only after the ID handshake.
- `rst` asserted during WAIT -> next cycle `req_valid_o = 1`, `req_addr_o = 0x80000000`, `inst_valid_o = 0`.
